uart_rx_pkt_ctrl: RTL and testbench

- Packet-level controller behind the 16x-oversampling UART byte receiver.
- Consumes the receiver's byte/valid output and parses frames of the form SYNC, ADDR, LEN, PAYLOAD[LEN], CSUM.
- Buffers the payload, checks the checksum, and on success replays the payload as a one-byte-per-cycle write burst to the downstream register/command logic.
- Sequences frame acceptance, timeout recovery and error reporting so downstream logic never sees a partial or corrupt frame.

---
 rtl/uart_rx_pkt_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind the UART byte receiver: parses SYNC/ADDR/LEN/PAYLOAD/CSUM frames,
// verifies the checksum and replays good payloads as a write burst. Optional macro: UART_PKT_ADDR_FILTER_EN.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int          MAX_LEN   = 16,
    parameter logic [15:0] TIMEOUT   = 16'd4000,
    parameter logic [7:0]  MY_ADDR   = 8'h01,
    localparam int         IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    iData,
    input  logic          iValid,
    output logic          oWrEn,
    output logic [IW-1:0] oWrIdx,
    output logic [7:0]    oWrData,
    output logic [7:0]    oAddr,
    output logic [7:0]    oLen,
    output logic          oPktDone,
    output logic          oPktErr,
    output logic [2:0]    oErrCode,
    output logic [15:0]   oPktCnt,
    output logic          oBusy
);

    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);
    localparam logic [2:0] E_CSUM    = 3'd1;
    localparam logic [2:0] E_LEN     = 3'd2;
    localparam logic [2:0] E_TMO     = 3'd3;
    localparam logic [2:0] E_OVR     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic        valid_q;
    logic        stb;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  addr_q, addr_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  idx_q, idx_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  oaddr_q, oaddr_d;
    logic [7:0]  olen_q, olen_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [2:0]  code_q, code_d;
    logic        mem_we;
    logic        in_frame;
    logic        tmo;
    logic        addr_ok;
    logic        wr_en;
    logic        done;
    logic [7:0]  mem_q [MAX_LEN];

    // One strobe per rising edge of the receiver's valid level
    assign stb = iValid & ~valid_q;

`ifdef UART_PKT_ADDR_FILTER_EN
    assign addr_ok = (addr_q == MY_ADDR) || (addr_q == 8'hFF);
`else
    logic unused_my_addr;
    assign unused_my_addr = ^MY_ADDR;
    assign addr_ok        = 1'b1;
`endif

    assign in_frame = (state_q == S_ADDR) || (state_q == S_LEN) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CSUM);
    assign tmo      = (timer_q == TIMEOUT - 16'd1);

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        timer_d = '0;
        oaddr_d = oaddr_q;
        olen_d  = olen_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        code_d  = code_q;
        mem_we  = 1'b0;
        wr_en   = 1'b0;
        done    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (stb && (iData == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                    sum_d   = '0;
                end
            end
            S_ADDR: begin
                if (stb) begin
                    addr_d  = iData;
                    sum_d   = sum_q + iData;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (stb) begin
                    if (iData == 8'd0) begin
                        len_d   = '0;
                        sum_d   = sum_q + iData;
                        state_d = S_CSUM;
                    end else if ({1'b0, iData} > MAX_LEN_W) begin
                        err_d   = 1'b1;
                        code_d  = E_LEN;
                        state_d = S_IDLE;
                    end else begin
                        len_d   = {1'b0, iData};
                        idx_d   = '0;
                        sum_d   = sum_q + iData;
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (stb) begin
                    mem_we = 1'b1;
                    sum_d  = sum_q + iData;
                    idx_d  = idx_q + 9'd1;
                    if (idx_q == len_q - 9'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (stb) begin
                    if (iData == sum_q) begin
                        if (addr_ok) begin
                            state_d = S_DRAIN;
                            idx_d   = '0;
                            oaddr_d = addr_q;
                            olen_d  = len_q[7:0];
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        err_d   = 1'b1;
                        code_d  = E_CSUM;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                // A byte arriving here is lost; the drain itself is never cut short
                if (stb) begin
                    err_d  = 1'b1;
                    code_d = E_OVR;
                end
                if (idx_q != len_q) begin
                    wr_en = 1'b1;
                    idx_d = idx_q + 9'd1;
                end else begin
                    done    = 1'b1;
                    cnt_d   = cnt_q + 16'd1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Inter-byte timer; a byte on the expiry cycle takes precedence
        if (in_frame && !stb) begin
            timer_d = timer_q + 16'd1;
            if (tmo) begin
                err_d   = 1'b1;
                code_d  = E_TMO;
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            sum_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            oaddr_q <= '0;
            olen_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= iValid;
            sum_q   <= sum_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            oaddr_q <= oaddr_d;
            olen_q  <= olen_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx_q[IW-1:0]] <= iData;
        end
    end

    assign oWrEn    = wr_en;
    assign oWrIdx   = wr_en ? idx_q[IW-1:0] : '0;
    assign oWrData  = wr_en ? mem_q[idx_q[IW-1:0]] : 8'h00;
    assign oPktDone = done;
    assign oAddr    = oaddr_q;
    assign oLen     = olen_q;
    assign oPktErr  = err_q;
    assign oErrCode = code_q;
    assign oPktCnt  = cnt_q;
    assign oBusy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: a frame table plus hand sequences for timeout, overrun,
// held-valid and mid-frame reset. Honours UART_PKT_ADDR_FILTER_EN when defined.
module tb_uart_rx_pkt_ctrl;

    localparam int TMO = 50;
`ifdef UART_PKT_ADDR_FILTER_EN
    localparam int FILT = 1;
`else
    localparam int FILT = 0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  iData;
    logic        iValid;
    logic        oWrEn;
    logic [3:0]  oWrIdx;
    logic [7:0]  oWrData;
    logic [7:0]  oAddr;
    logic [7:0]  oLen;
    logic        oPktDone;
    logic        oPktErr;
    logic [2:0]  oErrCode;
    logic [15:0] oPktCnt;
    logic        oBusy;

    uart_rx_pkt_ctrl #(
        .SYNC_BYTE (8'hA5),
        .MAX_LEN   (16),
        .TIMEOUT   (16'(TMO)),
        .MY_ADDR   (8'h01)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .iData    (iData),
        .iValid   (iValid),
        .oWrEn    (oWrEn),
        .oWrIdx   (oWrIdx),
        .oWrData  (oWrData),
        .oAddr    (oAddr),
        .oLen     (oLen),
        .oPktDone (oPktDone),
        .oPktErr  (oPktErr),
        .oErrCode (oErrCode),
        .oPktCnt  (oPktCnt),
        .oBusy    (oBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor: cumulative counts and a log of every write beat
    int wr_tot   = 0;
    int done_tot = 0;
    int err_tot  = 0;
    int wr_data_log [1024];
    int wr_idx_log  [1024];

    always @(negedge clk) begin
        if (oWrEn) begin
            wr_data_log[wr_tot % 1024] <= int'(oWrData);
            wr_idx_log[wr_tot % 1024]  <= int'(oWrIdx);
            wr_tot <= wr_tot + 1;
        end
        if (oPktDone) done_tot <= done_tot + 1;
        if (oPktErr)  err_tot  <= err_tot + 1;
    end

    typedef struct {
        logic [7:0] b [20];
        int         n;
        int         exp_wr;
        int         exp_done;
        int         exp_err;
        int         exp_code;
        logic [7:0] exp_addr;
        logic [7:0] exp_len;
    } vec_t;

    vec_t vecs [12];
    int   nv = 0;
    int   total = 0;
    int   bad = 0;
    int   cnt_exp = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic add(input logic [159:0] s, input int n, input int wr, input int dn,
                       input int er, input int code, input logic [7:0] a, input logic [7:0] l);
        for (int i = 0; i < 20; i++) vecs[nv].b[i] = 8'h00;
        for (int i = 0; i < n; i++) vecs[nv].b[i] = s[8*(n-1-i) +: 8];
        vecs[nv].n        = n;
        vecs[nv].exp_wr   = wr;
        vecs[nv].exp_done = dn;
        vecs[nv].exp_err  = er;
        vecs[nv].exp_code = code;
        vecs[nv].exp_addr = a;
        vecs[nv].exp_len  = l;
        nv++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        iData  = b;
        iValid = 1'b1;
        repeat (hi) @(negedge clk);
        iValid = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic wait_err(input int e0, input int lim, output int seen);
        seen = 0;
        for (int i = 0; i < lim && seen == 0; i++) begin
            @(negedge clk);
            if (err_tot != e0) seen = 1;
        end
    endtask

    task automatic send_frame16(input int last_hi);
        logic [7:0] csum;
        csum = 8'h11;
        send_byte(8'hA5, 2, 2);
        send_byte(8'h01, 2, 2);
        send_byte(8'h10, 2, 2);
        for (int i = 1; i <= 16; i++) begin
            send_byte(8'(i), 2, 2);
            csum = csum + 8'(i);
        end
        send_byte(csum, last_hi, 2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, d0, e0, seen;

        add({8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h64}, 7, 3, 1, 0, 0, 8'h01, 8'h03);
        add({8'hA5, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'h00}, 6, 0, 0, 1, 1, 8'h00, 8'h00);
        add({8'hA5, 8'h02, 8'h02, 8'h05, 8'h06, 8'h0F}, 6, FILT ? 0 : 2, FILT ? 0 : 1, 0, 0, 8'h02, 8'h02);
        add({8'hA5, 8'h01, 8'h11, 8'h05, 8'h06}, 5, 0, 0, 1, 2, 8'h00, 8'h00);
        add({8'hA5, 8'h07, 8'h00, 8'h07}, 4, 0, FILT ? 0 : 1, 0, 0, 8'h07, 8'h00);
        add({8'h00, 8'hFF}, 2, 0, 0, 0, 0, 8'h00, 8'h00);
        add({8'hA5, 8'h01, 8'h01, 8'hAA, 8'hAC}, 5, 1, 1, 0, 0, 8'h01, 8'h01);
        add({8'hA5, 8'h01, 8'h10, 128'h0102030405060708090A0B0C0D0E0F10, 8'h99}, 20, 16, 1, 0, 0, 8'h01, 8'h10);
        add({8'hA5, 8'h02, 8'h01, 8'h55, 8'h58}, 5, FILT ? 0 : 1, FILT ? 0 : 1, 0, 0, 8'h02, 8'h01);
        add({8'hA5, 8'hFF, 8'h01, 8'h55, 8'h55}, 5, 1, 1, 0, 0, 8'hFF, 8'h01);

        reset  = 1'b0;
        iValid = 1'b0;
        iData  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_wren", int'(oWrEn), 0);
        chk("rst_done", int'(oPktDone), 0);
        chk("rst_err", int'(oPktErr), 0);
        chk("rst_code", int'(oErrCode), 0);
        chk("rst_cnt", int'(oPktCnt), 0);
        chk("rst_busy", int'(oBusy), 0);
        chk("rst_addr", int'(oAddr), 0);
        chk("rst_wrdata", int'(oWrData), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < nv; k++) begin
            w0 = wr_tot;
            d0 = done_tot;
            e0 = err_tot;
            for (int i = 0; i < vecs[k].n; i++) send_byte(vecs[k].b[i], 2, 2);
            repeat (25) @(negedge clk);
            cnt_exp += vecs[k].exp_done;
            chk($sformatf("v%0d_wr", k), wr_tot - w0, vecs[k].exp_wr);
            chk($sformatf("v%0d_done", k), done_tot - d0, vecs[k].exp_done);
            chk($sformatf("v%0d_err", k), err_tot - e0, vecs[k].exp_err);
            chk($sformatf("v%0d_cnt", k), int'(oPktCnt), cnt_exp);
            chk($sformatf("v%0d_busy", k), int'(oBusy), 0);
            if (vecs[k].exp_err != 0)
                chk($sformatf("v%0d_code", k), int'(oErrCode), vecs[k].exp_code);
            if (vecs[k].exp_done != 0) begin
                chk($sformatf("v%0d_addr", k), int'(oAddr), int'(vecs[k].exp_addr));
                chk($sformatf("v%0d_len", k), int'(oLen), int'(vecs[k].exp_len));
            end
            for (int i = 0; i < vecs[k].exp_wr; i++) begin
                chk($sformatf("v%0d_data%0d", k, i), wr_data_log[(w0 + i) % 1024], int'(vecs[k].b[3 + i]));
                chk($sformatf("v%0d_idx%0d", k, i), wr_idx_log[(w0 + i) % 1024], i);
            end
        end

        // Timeout after SYNC, ADDR
        e0 = err_tot;
        w0 = wr_tot;
        send_byte(8'hA5, 2, 2);
        send_byte(8'h01, 2, 2);
        repeat (TMO - 10) @(negedge clk);
        chk("tmo_busy_before", int'(oBusy), 1);
        chk("tmo_early_err", err_tot - e0, 0);
        wait_err(e0, 30, seen);
        chk("tmo_seen", seen, 1);
        @(negedge clk);
        chk("tmo_code", int'(oErrCode), 3);
        chk("tmo_busy_after", int'(oBusy), 0);

        // Repeated SYNC becomes ADDR, missing checksum times out
        e0 = err_tot;
        send_byte(8'hA5, 2, 2);
        send_byte(8'hA5, 2, 2);
        send_byte(8'h02, 2, 2);
        send_byte(8'h00, 2, 2);
        send_byte(8'h02, 2, 2);
        chk("garb_busy", int'(oBusy), 1);
        wait_err(e0, TMO + 20, seen);
        chk("garb_seen", seen, 1);
        @(negedge clk);
        chk("garb_code", int'(oErrCode), 3);
        chk("garb_wr", wr_tot - w0, 0);
        chk("garb_busy_after", int'(oBusy), 0);

        // Valid held high ten cycles per byte
        d0 = done_tot;
        e0 = err_tot;
        w0 = wr_tot;
        send_byte(8'hA5, 10, 2);
        send_byte(8'h01, 10, 2);
        send_byte(8'h00, 10, 2);
        send_byte(8'h01, 10, 2);
        repeat (10) @(negedge clk);
        cnt_exp += 1;
        chk("hold_done", done_tot - d0, 1);
        chk("hold_err", err_tot - e0, 0);
        chk("hold_wr", wr_tot - w0, 0);
        chk("hold_len", int'(oLen), 0);
        chk("hold_cnt", int'(oPktCnt), cnt_exp);

        // Byte arriving during drain: overrun, drain still completes
        d0 = done_tot;
        e0 = err_tot;
        w0 = wr_tot;
        send_frame16(1);
        send_byte(8'h33, 1, 2);
        repeat (25) @(negedge clk);
        cnt_exp += 1;
        chk("ovr_wr", wr_tot - w0, 16);
        chk("ovr_done", done_tot - d0, 1);
        chk("ovr_err", err_tot - e0, 1);
        chk("ovr_code", int'(oErrCode), 4);
        chk("ovr_cnt", int'(oPktCnt), cnt_exp);
        chk("ovr_first", wr_data_log[w0 % 1024], 1);
        chk("ovr_last", wr_data_log[(w0 + 15) % 1024], 16);
        chk("ovr_busy", int'(oBusy), 0);

        // Reset mid-frame aborts silently
        d0 = done_tot;
        e0 = err_tot;
        send_byte(8'hA5, 2, 2);
        send_byte(8'h01, 2, 2);
        send_byte(8'h03, 2, 2);
        send_byte(8'h10, 2, 2);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("mrst_busy", int'(oBusy), 0);
        chk("mrst_cnt", int'(oPktCnt), 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("mrst_done", done_tot - d0, 0);
        chk("mrst_err", err_tot - e0, 0);
        w0 = wr_tot;
        for (int i = 0; i < vecs[0].n; i++) send_byte(vecs[0].b[i], 2, 2);
        repeat (20) @(negedge clk);
        chk("mrst_after_wr", wr_tot - w0, 3);
        chk("mrst_after_cnt", int'(oPktCnt), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
